// File: rtl/cdb_arbiter_if.sv
// Complete-stage bus between the FUs/ROB and the CDB arbiter.
// master: FU results and rollback info out, grants and CDB in; slave: arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_FU  = 4,
  parameter int NUM_PR  = 64,
  parameter int NUM_ROB = 8
);
  localparam int PRW  = $clog2(NUM_PR);
  localparam int ROBW = $clog2(NUM_ROB);

  logic [NUM_FU-1:0]      fu_done;
  logic [NUM_FU*PRW-1:0]  fu_T_idx;
  logic [NUM_FU*ROBW-1:0] fu_ROB_idx;
  logic [NUM_FU*64-1:0]   fu_result;
  logic                   ROB_rollback_en;
  logic [ROBW-1:0]        ROB_rollback_idx;
  logic [ROBW-1:0]        diff_ROB;

  logic [NUM_FU-1:0]      CDB_valid;
  logic                   CDB_bcast_valid;
  logic [PRW-1:0]         CDB_T_idx;
  logic [ROBW-1:0]        CDB_ROB_idx;
  logic [63:0]            CDB_value;

  modport master (
    output fu_done,
    output fu_T_idx,
    output fu_ROB_idx,
    output fu_result,
    output ROB_rollback_en,
    output ROB_rollback_idx,
    output diff_ROB,
    input  CDB_valid,
    input  CDB_bcast_valid,
    input  CDB_T_idx,
    input  CDB_ROB_idx,
    input  CDB_value
  );

  modport slave (
    input  fu_done,
    input  fu_T_idx,
    input  fu_ROB_idx,
    input  fu_result,
    input  ROB_rollback_en,
    input  ROB_rollback_idx,
    input  diff_ROB,
    output CDB_valid,
    output CDB_bcast_valid,
    output CDB_T_idx,
    output CDB_ROB_idx,
    output CDB_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin complete-stage arbiter driving a registered CDB broadcast.
// Ports: clock, reset (sync, active-low), bus (cdb_arbiter_if.slave).
module cdb_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int NUM_PR  = 64,
  parameter int NUM_ROB = 8
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int PRW  = $clog2(NUM_PR);
  localparam int ROBW = $clog2(NUM_ROB);
  localparam int FUW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  localparam logic [PRW-1:0] ZERO_PR = PRW'(NUM_PR - 1);
  localparam logic [FUW:0]   NFU     = (FUW+1)'(NUM_FU);

  logic [NUM_FU-1:0] squash;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [ROBW-1:0]   off [NUM_FU];

  logic [FUW-1:0] rr_ptr;
  logic [FUW-1:0] gnt_idx;
  logic [FUW-1:0] nxt_ptr;
  logic [FUW:0]   idx_ext;
  logic [FUW:0]   nxt_ext;
  logic           found;

  // Distance from the mispredicted branch in ROB order; anything
  // strictly between the branch and the tail is wrong-path.
  always_comb begin
    squash = '0;
    req    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      off[i] = bus.fu_ROB_idx[i*ROBW +: ROBW]
             - bus.ROB_rollback_idx;
      squash[i] = bus.ROB_rollback_en
               && (off[i] != '0)
               && (off[i] < bus.diff_ROB);
      req[i] = bus.fu_done[i] && !squash[i];
    end
  end

  // First eligible index at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx_ext = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx_ext = {1'b0, rr_ptr} + (FUW+1)'(j);
      if (idx_ext >= NFU)
        idx_ext = idx_ext - NFU;
      if (!found && req[idx_ext[FUW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx_ext[FUW-1:0];
      end
    end
    if (found)
      grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    nxt_ext = {1'b0, gnt_idx} + 1'b1;
    if (nxt_ext >= NFU)
      nxt_ext = '0;
    nxt_ptr = nxt_ext[FUW-1:0];
  end

  // Grants are withheld during reset so no FU advances.
  assign bus.CDB_valid = reset ? grant : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr              <= '0;
      bus.CDB_bcast_valid <= 1'b0;
      bus.CDB_T_idx       <= ZERO_PR;
      bus.CDB_ROB_idx     <= '0;
      bus.CDB_value       <= '0;
    end else begin
      bus.CDB_bcast_valid <= found;
      if (found) begin
        rr_ptr          <= nxt_ptr;
        bus.CDB_T_idx   <= bus.fu_T_idx[gnt_idx*PRW +: PRW];
        bus.CDB_ROB_idx <= bus.fu_ROB_idx[gnt_idx*ROBW +: ROBW];
        bus.CDB_value   <= bus.fu_result[gnt_idx*64 +: 64];
      end
    end
  end

endmodule
